if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core. Holds the PC, drives the instruction-memory address, and latches the fetched instruction and PC+4 into IF/ID for the decode stage. The decode stage's main control decoder reads the opcode from that register. Handles load-use stalls, jump redirects from ID, and taken-branch redirects from later in the pipe, inserting bubbles on redirect.

---
 rtl/if_stage_if.sv | 43 ++++
 rtl/if_stage.sv | 88 ++++++++
 tb/tb_if_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / memory.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jump;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  modport master (
    input  imem_rdata,
    input  stall,
    input  jump,
    input  branch_taken,
    input  branch_target,
    output imem_addr,
    output pc,
    output ifid_instr,
    output ifid_pc4,
    output ifid_valid,
    output fetch_count
  );

  modport slave (
    output imem_rdata,
    output stall,
    output jump,
    output branch_taken,
    output branch_target,
    input  imem_addr,
    input  pc,
    input  ifid_instr,
    input  ifid_pc4,
    input  ifid_valid,
    input  fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, imem address, IF/ID pipeline register.
// Ports: clk, rst_n (sync, active low), bus (if_stage_if.master).
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  if_stage_if.master bus
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{
    instr: NOP_INSTR,
    pc4:   32'd0,
    valid: 1'b0
  };

  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  if_id_t      ifid_q, ifid_d;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        take_br;
  logic        hold;
  logic        take_j;

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {ifid_q.pc4[31:28],
                        ifid_q.instr[25:0], 2'b00};

  // Mutually exclusive selects encode the redirect priority;
  // a bubble in IF/ID can never redirect.
  assign take_br = bus.branch_taken;
  assign hold    = !bus.branch_taken && bus.stall;
  assign take_j  = !bus.branch_taken && !bus.stall &&
                   bus.jump && ifid_q.valid;

  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      take_br: begin
        pc_d   = {bus.branch_target[31:2], 2'b00};
        ifid_d = BUBBLE;
      end
      hold: begin
      end
      take_j: begin
        pc_d   = jump_target;
        ifid_d = BUBBLE;
      end
      default: begin
        pc_d   = pc_plus4;
        ifid_d = '{instr: bus.imem_rdata,
                   pc4:   pc_plus4,
                   valid: 1'b1};
        cnt_d  = cnt_q + 32'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      ifid_q <= BUBBLE;
      cnt_q  <= 32'd0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.ifid_instr  = ifid_q.instr;
  assign bus.ifid_pc4    = ifid_q.pc4;
  assign bus.ifid_valid  = ifid_q.valid;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomised + directed bench for if_stage with a queue-based scoreboard.
// Reference model applies the fetch priority rules on plain variables.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a < 32'h1000) return mem[a[11:2]];
    return a ^ 32'h5A5A_1234;
  endfunction

  assign bus.imem_rdata = (bus.imem_addr < 32'h1000) ?
                          mem[bus.imem_addr[11:2]] :
                          (bus.imem_addr ^ 32'h5A5A_1234);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_bubble();
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  // Drive one cycle of stimulus and predict the state after the next edge.
  task automatic step(input logic rst, input logic br,
                      input logic [31:0] tgt, input logic st,
                      input logic j);
    exp_t e;
    @(negedge clk);
    rst_n             = rst;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.stall         = st;
    bus.jump          = j;
    if (!rst) begin
      m_pc = 32'h0;
      model_bubble();
      m_cnt = 32'h0;
    end else if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      model_bubble();
    end else if (st) begin
    end else if (j && m_valid) begin
      m_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
      model_bubble();
    end else begin
      m_instr = memword(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      m_pc    = m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
    e.valid = m_valid; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic fetch(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", bus.pc, e.pc);
        chk("imem_addr", bus.imem_addr, e.pc);
        chk("ifid_instr", bus.ifid_instr, e.instr);
        chk("ifid_pc4", bus.ifid_pc4, e.pc4);
        chk("ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, e.valid});
        chk("fetch_count", bus.fetch_count, e.cnt);
      end
    end
  end

  initial begin : stim
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.stall         = 1'b0;
    bus.jump          = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom();
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'h0000_0000;

    // reset then sequential fetch with a 3-cycle stall at pc=0x8
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch(2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    fetch(2);
    after_edge();
    chk("seq_count", bus.fetch_count, 32'd4);
    chk("seq_pc4", bus.ifid_pc4, 32'd16);
    chk("seq_instr", bus.ifid_instr, 32'h0);

    // jump from IF/ID word 0x08000040 at pc4 0x10
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    mem[3] = 32'h0800_0040;
    fetch(4);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    after_edge();
    chk("jump_pc", bus.pc, 32'h100);
    chk("jump_bubble", {31'd0, bus.ifid_valid}, 32'd0);
    // jump while IF/ID holds a bubble is ignored
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    after_edge();
    chk("jbub_pc", bus.pc, 32'h104);
    chk("jtgt_instr", bus.ifid_instr, mem[64]);

    // branch beats stall and jump; low target bits masked
    step(1'b1, 1'b1, 32'h203, 1'b1, 1'b1);
    after_edge();
    chk("br_pc", bus.pc, 32'h200);

    // PC wrap then a one-cycle mid-run reset
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    fetch(1);
    after_edge();
    chk("wrap_pc", bus.pc, 32'h0);
    chk("wrap_pc4", bus.ifid_pc4, 32'h0);
    fetch(2);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch(3);

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic r, b, s, jj;
      logic [31:0] t;
      r  = ($urandom_range(0, 49) != 0);
      b  = ($urandom_range(0, 9) == 0);
      s  = ($urandom_range(0, 3) == 0);
      jj = ($urandom_range(0, 4) == 0);
      t  = ($urandom_range(0, 7) == 0) ? $urandom() :
           32'($urandom_range(0, 4095));
      step(r, b, t, s, jj);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
